// File: rtl/mux6_rr_arbiter_pkg.sv
// Shared definitions for the 6:1 operand-mux round-robin arbiter:
// select width, idle select code, FSM state encoding and a one-hot to index helper.
package mux_arb_pkg;

  localparam int MAXREQ = 6;
  localparam int SELW   = 3;
  localparam logic [SELW-1:0] IDLE_SEL = 3'b110;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  // Binary index of a one-hot vector; all-zero input yields 0.
  function automatic logic [SELW-1:0] oh2idx(input logic [MAXREQ-1:0] oh);
    logic [SELW-1:0] idx;
    idx = '0;
    for (int i = 0; i < MAXREQ; i++)
      if (oh[i]) idx = idx | SELW'(i);
    return idx;
  endfunction

endpackage

// File: rtl/mux6_rr_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request scanning ptr+1, ptr+2, ... mod NREQ.
module rr_pick
  import mux_arb_pkg::*;
#(
  parameter int NREQ = 6
) (
  input  logic [NREQ-1:0] i_req_masked,
  input  logic [SELW-1:0] i_ptr,
  output logic            o_found,
  output logic [SELW-1:0] o_idx,
  output logic [NREQ-1:0] o_onehot
);

  localparam logic [SELW:0] NREQ_W = (SELW+1)'(NREQ);

  logic [SELW:0]   w_j;
  logic [NREQ-1:0] w_sh;

  // Walk the ring farthest-first so the nearest hit after ptr is the last write.
  always_comb begin
    o_found = 1'b0;
    o_idx   = '0;
    w_j     = '0;
    w_sh    = '0;
    for (int k = NREQ; k >= 1; k--) begin
      w_j = {1'b0, i_ptr} + (SELW+1)'(k);
      if (w_j >= NREQ_W) w_j = w_j - NREQ_W;
      w_sh = i_req_masked >> w_j;
      if (w_sh[0]) begin
        o_found = 1'b1;
        o_idx   = w_j[SELW-1:0];
      end
    end
    o_onehot = o_found ? (NREQ'(1) << o_idx) : '0;
  end

endmodule

// File: rtl/mux6_rr_arbiter.sv
// Round-robin arbiter/sequencer for the shared 32-bit 6:1 operand mux.
// All outputs registered; back-to-back grants without bubbles.
// Optional macro ARB_LOCK_EN: lets a locked grantee keep the bus for up to MAX_BEATS beats.
module mux6_rr_arbiter
  import mux_arb_pkg::*;
#(
  parameter int NREQ      = 6,
  parameter int MAX_BEATS = 4
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic [NREQ-1:0] i_req,
  input  logic [NREQ-1:0] i_lock,
  input  logic            i_out_ready,
  output logic            o_out_valid,
  output logic [SELW-1:0] o_sel,
  output logic [NREQ-1:0] o_grant,
  output logic [NREQ-1:0] o_ack,
  output logic            o_busy
);

  state_t          r_state, w_state_nxt;
  logic [NREQ-1:0] r_grant, w_grant_nxt;
  logic [NREQ-1:0] r_ack, w_ack_nxt;
  logic [SELW-1:0] r_sel, w_sel_nxt;
  logic [SELW-1:0] r_ptr, w_ptr_nxt;
  logic            r_valid, w_valid_nxt;

  logic            w_hs;
  logic            w_keep;
  logic [SELW-1:0] w_g_idx;
  logic [SELW-1:0] w_pick_ptr;
  logic [NREQ-1:0] w_req_m;
  logic            w_found;
  logic [SELW-1:0] w_pick_idx;
  logic [NREQ-1:0] w_pick_oh;

  assign w_hs    = r_valid & i_out_ready;
  assign w_g_idx = oh2idx(MAXREQ'(r_grant));

  // While granting, the current grantee is excluded from the next pick (it drops req after ack).
  // In idle, the requester still seeing its ack pulse is excluded for the same reason.
  assign w_req_m    = (r_state == ST_GRANT) ? (i_req & ~r_grant) : (i_req & ~r_ack);
  assign w_pick_ptr = (r_state == ST_GRANT) ? w_g_idx : r_ptr;

  rr_pick #(.NREQ(NREQ)) u_pick (
    .i_req_masked (w_req_m),
    .i_ptr        (w_pick_ptr),
    .o_found      (w_found),
    .o_idx        (w_pick_idx),
    .o_onehot     (w_pick_oh)
  );

`ifdef ARB_LOCK_EN
  localparam int BCW = $clog2(MAX_BEATS + 1);
  logic [BCW-1:0] r_beat_cnt;

  assign w_keep = (|(i_lock & i_req & r_grant)) && (r_beat_cnt < BCW'(MAX_BEATS - 1));

  // Beats consumed by the current locked owner; cleared on every handoff.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)
      r_beat_cnt <= '0;
    else if (r_state == ST_GRANT && w_hs)
      r_beat_cnt <= w_keep ? r_beat_cnt + 1'b1 : '0;
  end
`else
  logic w_unused_lock;
  assign w_unused_lock = ^i_lock;
  assign w_keep        = 1'b0;
`endif

  // Next-state and next-output logic; registers hold unless a pick or handshake occurs.
  always_comb begin
    w_state_nxt = r_state;
    w_grant_nxt = r_grant;
    w_sel_nxt   = r_sel;
    w_valid_nxt = r_valid;
    w_ack_nxt   = '0;
    w_ptr_nxt   = r_ptr;
    case (r_state)
      ST_IDLE: begin
        if (w_found) begin
          w_state_nxt = ST_GRANT;
          w_grant_nxt = w_pick_oh;
          w_sel_nxt   = w_pick_idx;
          w_valid_nxt = 1'b1;
        end
      end
      ST_GRANT: begin
        if (w_hs) begin
          w_ack_nxt = r_grant;
          if (!w_keep) begin
            w_ptr_nxt = w_g_idx;
            if (w_found) begin
              w_grant_nxt = w_pick_oh;
              w_sel_nxt   = w_pick_idx;
            end else begin
              w_state_nxt = ST_IDLE;
              w_grant_nxt = '0;
              w_sel_nxt   = IDLE_SEL;
              w_valid_nxt = 1'b0;
            end
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // State and output registers; reset parks the ptr so requester 0 wins first.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
      r_grant <= '0;
      r_ack   <= '0;
      r_sel   <= IDLE_SEL;
      r_valid <= 1'b0;
      r_ptr   <= SELW'(NREQ - 1);
    end else begin
      r_state <= w_state_nxt;
      r_grant <= w_grant_nxt;
      r_ack   <= w_ack_nxt;
      r_sel   <= w_sel_nxt;
      r_valid <= w_valid_nxt;
      r_ptr   <= w_ptr_nxt;
    end
  end

  assign o_out_valid = r_valid;
  assign o_sel       = r_sel;
  assign o_grant     = r_grant;
  assign o_ack       = r_ack;
  assign o_busy      = r_valid;

endmodule

// File: tb/tb_mux6_rr_arbiter.sv
// Scoreboard bench for mux6_rr_arbiter (default build, lock ignored).
// A transaction-level model predicts each cycle's outputs into a queue; a monitor compares.
module tb_mux6_rr_arbiter;
  localparam int N = 6;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [N-1:0] req = '0, lock = '0;
  logic         rdy = 1'b0;
  logic         o_valid, o_busy;
  logic [2:0]   o_sel;
  logic [N-1:0] o_grant, o_ack;

  logic [3:0]   req4 = '0, lock4 = '0;
  logic         rdy4 = 1'b0;
  logic         v4, b4;
  logic [2:0]   s4;
  logic [3:0]   g4, a4;

  always #5 clk = ~clk;

  mux6_rr_arbiter #(.NREQ(N), .MAX_BEATS(4)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_req(req), .i_lock(lock), .i_out_ready(rdy),
    .o_out_valid(o_valid), .o_sel(o_sel), .o_grant(o_grant), .o_ack(o_ack), .o_busy(o_busy)
  );

  mux6_rr_arbiter #(.NREQ(4), .MAX_BEATS(4)) dut4 (
    .i_clk(clk), .i_rst_n(rst_n), .i_req(req4), .i_lock(lock4), .i_out_ready(rdy4),
    .o_out_valid(v4), .o_sel(s4), .o_grant(g4), .o_ack(a4), .o_busy(b4)
  );

  typedef struct packed {
    logic         v;
    logic [2:0]   sel;
    logic [N-1:0] gnt;
    logic [N-1:0] ack;
    logic         busy;
  } obs_t;

  obs_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  // Reference model: current grantee (-1 = none), rotation pointer, last ack.
  int         m_g = -1;
  int         m_ptr = N - 1;
  logic [N-1:0] m_ack = '0;

  function automatic int scan(input int ptr, input logic [N-1:0] m);
    for (int k = 1; k <= N; k++) begin
      int j;
      j = (ptr + k) % N;
      if (m[j]) return j;
    end
    return -1;
  endfunction

  always @(posedge clk) begin
    obs_t e;
    bit   hs;
    logic [N-1:0] m;
    if (!rst_n) begin
      m_g = -1; m_ptr = N - 1; m_ack = '0;
    end else begin
      hs    = (m_g >= 0) && rdy;
      m_ack = '0;
      if (hs) m_ack[m_g] = 1'b1;
      if (m_g < 0) m_g = scan(m_ptr, req);
      else if (hs) begin
        m = req;
        m[m_g] = 1'b0;
        m_ptr = m_g;
        m_g = scan(m_ptr, m);
      end
    end
    e.v    = (m_g >= 0);
    e.sel  = (m_g >= 0) ? 3'(m_g) : 3'b110;
    e.gnt  = '0;
    if (m_g >= 0) e.gnt[m_g] = 1'b1;
    e.ack  = m_ack;
    e.busy = e.v;
    exp_q.push_back(e);
  end

  // Monitor: compare one predicted cycle per falling edge, plus NREQ=4 range check.
  always @(negedge clk) begin
    obs_t e, a;
    bit   ok4;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a.v = o_valid; a.sel = o_sel; a.gnt = o_grant; a.ack = o_ack; a.busy = o_busy;
      n_vec++;
      if (a !== e) begin
        n_err++;
        $display("FAIL cycle t=%0t got v=%b sel=%b gnt=%b ack=%b busy=%b exp v=%b sel=%b gnt=%b ack=%b busy=%b",
                 $time, a.v, a.sel, a.gnt, a.ack, a.busy, e.v, e.sel, e.gnt, e.ack, e.busy);
      end
      ok4 = v4 ? (s4 < 3'd4 && g4 == (4'd1 << s4)) : (s4 == 3'b110 && g4 == 4'd0);
      n_vec++;
      if (!ok4) begin
        n_err++;
        $display("FAIL nreq4_range t=%0t got v=%b sel=%b gnt=%b", $time, v4, s4, g4);
      end
    end
  end

  // Requesters hold req until acked; new requests arrive at req_pct, ready at rdy_pct.
  task automatic run(input int cycles, input int req_pct, input int rdy_pct);
    repeat (cycles) begin
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
        if (o_ack[i]) req[i] = 1'b0;
        else if (!req[i] && $urandom_range(99) < req_pct) req[i] = 1'b1;
      end
      for (int i = 0; i < 4; i++) begin
        if (a4[i]) req4[i] = 1'b0;
        else if (!req4[i] && $urandom_range(99) < 50) req4[i] = 1'b1;
      end
      rdy   = ($urandom_range(99) < rdy_pct);
      rdy4  = $urandom_range(1) == 1;
      lock  = 6'($urandom);
      lock4 = 4'($urandom);
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Single requester 0: grant next cycle, ack, then back to idle.
    @(negedge clk);
    req = 6'b000001; rdy = 1'b1;
    run(6, 0, 100);

    // All requesters continuously: strict rotation with no bubbles.
    run(30, 100, 100);
    // Mixed traffic and a starved consumer.
    run(200, 30, 50);
    run(40, 60, 10);

    // Asynchronous reset between edges while a beat is outstanding.
    req = '1; rdy = 1'b0;
    for (int k = 0; k < 20 && !o_valid; k++) @(negedge clk);
    n_vec++;
    if (!o_valid) begin
      n_err++;
      $display("FAIL grant_wait got valid=%b need 1", o_valid);
    end
    #2 rst_n = 1'b0;
    #1;
    n_vec++;
    if (o_valid !== 1'b0 || o_grant !== '0 || o_ack !== '0 || o_sel !== 3'b110 || o_busy !== 1'b0) begin
      n_err++;
      $display("FAIL async_reset got v=%b gnt=%b ack=%b sel=%b need 0/0/0/110", o_valid, o_grant, o_ack, o_sel);
    end
    req = '0; req4 = '0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    req = 6'b100000; rdy = 1'b1;
    run(6, 0, 100);

    run(300, 50, 70);
    run(20, 0, 100);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
